i2s_frame_buffer_ctrl: RTL and testbench
========================================

Name: i2s_frame_buffer_ctrl

Overview:
- Sits between the I2S receiver (one stereo frame pulse plus two 32-bit channel words) and the downstream audio consumer.
- Buffers stereo frames in an internal FIFO, supervises receiver lock with a frame watchdog, and prefills before streaming.
- Schedules output through a valid/ready handshake; on underrun it re-enters prefill.
- Counts overflow and underrun events for firmware visibility.

Parameters:
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 stereo frames.
- START_LEVEL, 8, frames buffered before output starts; legal range 1..2**DEPTH_LOG2.
- TIMEOUT, 4096, clk cycles without a frame before lock is declared lost; must be ≥ 2.

Ports:
- clk  in  1  system clock
- nrst  in  1  reset, synchronous, active-low
- enable  in  1  firmware stream enable
- in_en  in  1  one-cycle frame-complete pulse from the receiver
- in_left  in  32  left sample, valid with in_en
- in_right  in  32  right sample, valid with in_en
- out_ready  in  1  consumer accepts a frame
- out_valid  out  1  head frame available
- out_left  out  32  head left sample (show-ahead)
- out_right  out  32  head right sample (show-ahead)
- level  out  DEPTH_LOG2+1  frames currently stored
- locked  out  1  receiver delivering frames
- overflow_cnt  out  16  dropped-frame count, saturating
- underflow_cnt  out  16  underrun count, saturating

Behaviour:
- Reset (nrst=0 at a clk edge):
  - state=S_IDLE; pointers, level, watchdog and both counters = 0; locked=0; out_valid=0.
  - out_left and out_right = 0.
- Watchdog (runs in all states):
  - in_en clears the watchdog and sets locked=1 at the next edge.
  - Otherwise the watchdog increments. When it reaches TIMEOUT-1, locked is cleared at the next edge and the watchdog saturates.
- States:
  - S_IDLE:
    - FIFO flushed every cycle (pointers and level = 0); in_en frames discarded and not counted; out_valid=0.
    - Go to S_FILL when enable=1 and locked=1.
  - S_FILL:
    - Frames written; out_valid=0; no pops.
    - Go to S_RUN when level ≥ START_LEVEL, using the registered level.
  - S_RUN:
    - out_valid = (level != 0). A pop occurs when out_valid & out_ready.
    - A cycle with level==0 and out_ready=1 is an underrun: underflow_cnt+1 (saturating at 0xFFFF) and go to S_FILL.
  - From S_FILL or S_RUN: enable=0 or locked=0 → S_IDLE at the next edge. This has priority over the other transitions.
- Write path (S_FILL and S_RUN):
  - in_en with level < depth: write at the write pointer, which then increments and wraps modulo depth.
  - Full with a same-cycle pop: write accepted, level unchanged.
  - Full with no pop: frame dropped, overflow_cnt+1 (saturating), FIFO contents unchanged.
- Level:
  - push only → +1; pop only → −1; push and pop together → unchanged.
  - level can reach exactly 2**DEPTH_LOG2.
- Latency:
  - A frame pushed at edge N is counted in level after N.
  - In S_RUN with level==0, the frame is presented on out_* in cycle N+1.
- Output data:
  - out_left/out_right = memory[read pointer] whenever out_valid=1.
  - They are held at the last head value when out_valid=0 and are don't-care for checking.
- Reset mid-stream: all state is discarded immediately and no partial frame survives.

Decomposition:
- Shared package:
  - state encoding S_IDLE/S_FILL/S_RUN, one-hot, matching the receiver FSM style.
  - SAMPLE_W=32 and FRAME_W=64 constants.
- One sub-module, i2s_frame_fifo:
  - synchronous show-ahead FIFO of FRAME_W × 2**DEPTH_LOG2.
  - ports: push, pop, flush, din, dout, level.
  - the controller owns the FSM, watchdog, counters and overflow/underrun decisions.

Test Plan:
- Lock and prefill:
  - Stimulus: enable=1; send 8 frames with left=i, right=~i.
  - Response: locked rises after frame 1; out_valid rises the cycle after level reaches 8; frames are output in order 0..7 with out_ready=1.
- Overflow:
  - Stimulus: out_ready=0 in S_RUN; push 20 frames.
  - Response: level saturates at 16; overflow_cnt=4; frames 16..19 are absent from the drained sequence.
- Underrun:
  - Stimulus: drain all frames with out_ready=1.
  - Response: underflow_cnt=1; state returns to S_FILL; out_valid=0 until 8 new frames arrive.
- Simultaneous push and pop at full:
  - Stimulus: level=16; in_en and out_ready both asserted.
  - Response: level stays 16; overflow_cnt unchanged; the new frame appears after 15 further pops.
- Watchdog:
  - Stimulus: TIMEOUT=16; stop in_en.
  - Response: locked falls 16 cycles after the last in_en; state goes to S_IDLE; level=0 one cycle later; a resumed frame re-locks and restarts prefill.
- Reset and enable mid-stream:
  - Stimulus: pulse nrst=0 for one edge in S_RUN with level=5.
  - Response: all outputs and counters = 0 on the next cycle.
  - Stimulus: deassert enable instead of the reset pulse.
  - Response: counters retained; FIFO flushed.

Source files
------------

// File: rtl/i2s_frame_buffer_ctrl_pkg.sv
// i2s_frame_buffer_ctrl_pkg: shared state encoding, frame widths and counter helper
package i2s_frame_buffer_ctrl_pkg;
  localparam int SAMPLE_W = 32;
  localparam int FRAME_W  = 2 * SAMPLE_W;
  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_FILL = 3'b010,
    S_RUN  = 3'b100
  } state_t;
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
    return v + 16'(inc && v != 16'hFFFF);
  endfunction
endpackage

// File: rtl/i2s_frame_fifo.sv
// i2s_frame_fifo: synchronous show-ahead stereo frame FIFO with flush
module i2s_frame_fifo
  import i2s_frame_buffer_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [FRAME_W-1:0]    din,
  output logic [FRAME_W-1:0]    dout,
  output logic [DEPTH_LOG2:0]   level
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  logic [FRAME_W-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH_LOG2:0]   lvl_q, lvl_d;
  logic                  do_push, do_pop;
  always_comb begin
    do_pop  = pop && !flush && lvl_q != '0;
    do_push = push && !flush && (lvl_q != FULL || do_pop);
    wr_d    = flush ? '0 : wr_q + DEPTH_LOG2'(do_push);
    rd_d    = flush ? '0 : rd_q + DEPTH_LOG2'(do_pop);
    lvl_d   = flush ? '0 : lvl_q + (DEPTH_LOG2 + 1)'(do_push) - (DEPTH_LOG2 + 1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end
  // storage is not reset; only the pointers define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
  assign dout  = mem_q[rd_q];
  assign level = lvl_q;
endmodule

// File: rtl/i2s_frame_buffer_ctrl.sv
// i2s_frame_buffer_ctrl: I2S frame buffering with lock watchdog, prefill and underrun recovery
module i2s_frame_buffer_ctrl
  import i2s_frame_buffer_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2  = 4,
  parameter int START_LEVEL = 8,
  parameter int TIMEOUT     = 4096
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  enable,
  input  logic                  in_en,
  input  logic [SAMPLE_W-1:0]   in_left,
  input  logic [SAMPLE_W-1:0]   in_right,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [SAMPLE_W-1:0]   out_left,
  output logic [SAMPLE_W-1:0]   out_right,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  locked,
  output logic [15:0]           overflow_cnt,
  output logic [15:0]           underflow_cnt
);
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]     WD_MAX = WD_W'(TIMEOUT - 1);
  localparam logic [DEPTH_LOG2:0] FULL   = (DEPTH_LOG2 + 1)'(2 ** DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] START  = (DEPTH_LOG2 + 1)'(START_LEVEL);
  state_t             state_q, state_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               locked_q, locked_d;
  logic [15:0]        ovf_q, ovf_d, unf_q, unf_d;
  logic [FRAME_W-1:0] hold_q, hold_d, fifo_dout;
  logic               push, pop, flush, full, ovf_ev, underrun, stop;
  i2s_frame_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({in_left, in_right}),
    .dout  (fifo_dout),
    .level (level)
  );
  always_comb begin
    flush     = state_q == S_IDLE;
    full      = level == FULL;
    out_valid = state_q == S_RUN && level != '0;
    pop       = out_valid && out_ready;
    push      = in_en && !flush && (!full || pop);
    ovf_ev    = in_en && !flush && full && !pop;
    underrun  = state_q == S_RUN && level == '0 && out_ready;
    stop      = !enable || !locked_q;
    // watchdog saturates at TIMEOUT-1 so a lost lock stays lost until a frame arrives
    wd_d      = in_en ? '0 : (wd_q == WD_MAX ? wd_q : wd_q + WD_W'(1));
    locked_d  = in_en ? 1'b1 : (wd_q == WD_MAX ? 1'b0 : locked_q);
    ovf_d     = sat_inc(ovf_q, ovf_ev);
    unf_d     = sat_inc(unf_q, underrun);
    hold_d    = out_valid ? fifo_dout : hold_q;
    state_d   = state_q;
    case (state_q)
      S_IDLE:  state_d = (enable && locked_q) ? S_FILL : S_IDLE;
      S_FILL:  state_d = stop ? S_IDLE : (level >= START ? S_RUN : S_FILL);
      S_RUN:   state_d = stop ? S_IDLE : (underrun ? S_FILL : S_RUN);
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= S_IDLE;
      wd_q     <= '0;
      locked_q <= 1'b0;
      ovf_q    <= '0;
      unf_q    <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      wd_q     <= wd_d;
      locked_q <= locked_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      hold_q   <= hold_d;
    end
  end
  assign out_left      = out_valid ? fifo_dout[FRAME_W-1 -: SAMPLE_W] : hold_q[FRAME_W-1 -: SAMPLE_W];
  assign out_right     = out_valid ? fifo_dout[SAMPLE_W-1:0] : hold_q[SAMPLE_W-1:0];
  assign locked        = locked_q;
  assign overflow_cnt  = ovf_q;
  assign underflow_cnt = unf_q;
endmodule

// File: tb/tb_i2s_frame_buffer_ctrl.sv
// tb_i2s_frame_buffer_ctrl: directed scoreboard bench for the I2S frame buffer controller
module tb_i2s_frame_buffer_ctrl;
  logic        clk = 1'b0, nrst = 1'b0, enable = 1'b0, in_en = 1'b0, out_ready = 1'b0;
  logic [31:0] in_left = '0, in_right = '0;
  logic        out_valid, locked;
  logic [31:0] out_left, out_right;
  logic [4:0]  level;
  logic [15:0] overflow_cnt, underflow_cnt;
  int          checks = 0, failures = 0;
  logic [63:0] exp_q [$];

  i2s_frame_buffer_ctrl #(.DEPTH_LOG2(4), .START_LEVEL(8), .TIMEOUT(16)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .enable        (enable),
    .in_en         (in_en),
    .in_left       (in_left),
    .in_right      (in_right),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_left      (out_left),
    .out_right     (out_right),
    .level         (level),
    .locked        (locked),
    .overflow_cnt  (overflow_cnt),
    .underflow_cnt (underflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: drive inputs, score any handshake, queue the frame if it should come out later
  task automatic cyc(input logic en, input int v, input logic rdy, input logic keep);
    logic [63:0] f;
    f = {32'(v), ~32'(v)};
    in_en = en;
    in_left = f[63:32];
    in_right = f[31:0];
    out_ready = rdy;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL pop_empty: observed=%0h expected=no_frame", {out_left, out_right});
      end else chk("pop_data", {out_left, out_right}, exp_q.pop_front());
    end
    if (en && keep) exp_q.push_back(f);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_level"}, 64'(level), 64'(0));
    chk({tag, "_locked"}, 64'(locked), 64'(0));
    chk({tag, "_ovf"}, 64'(overflow_cnt), 64'(0));
    chk({tag, "_unf"}, 64'(underflow_cnt), 64'(0));
    chk({tag, "_out"}, {out_left, out_right}, 64'(0));
  endtask

  initial begin
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    nrst = 1'b1;
    chk_zero("reset");
    // lock with a discarded preamble frame, then prefill frames 0..7
    enable = 1'b1;
    cyc(1, 32'hA5A5, 0, 0);
    chk("lock_rise", 64'(locked), 64'(1));
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, i, 0, 1);
      if (i == 6) chk("prefill7_valid", 64'(out_valid), 64'(0));
    end
    chk("prefill_level", 64'(level), 64'(8));
    chk("prefill8_valid", 64'(out_valid), 64'(0));
    cyc(0, 0, 0, 0);
    chk("run_valid", 64'(out_valid), 64'(1));
    chk("run_head", {out_left, out_right}, {32'd0, 32'hFFFF_FFFF});
    repeat (8) cyc(0, 0, 1, 0);
    chk("drain_level", 64'(level), 64'(0));
    // overflow: 20 pushes with the consumer stalled, the last 4 are dropped
    for (int i = 0; i < 20; i++) cyc(1, 100 + i, 0, i < 16);
    chk("ovf_level", 64'(level), 64'(16));
    chk("ovf_cnt", 64'(overflow_cnt), 64'(4));
    // push and pop together while full
    cyc(1, 200, 1, 1);
    chk("fullpp_level", 64'(level), 64'(16));
    chk("fullpp_ovf", 64'(overflow_cnt), 64'(4));
    // drain to empty, with one mid-drain frame to keep the lock alive
    repeat (8) cyc(0, 0, 1, 0);
    cyc(1, 201, 1, 1);
    repeat (8) cyc(0, 0, 1, 0);
    chk("empty_level", 64'(level), 64'(0));
    chk("pre_unf", 64'(underflow_cnt), 64'(0));
    cyc(0, 0, 1, 0);
    chk("unf_cnt", 64'(underflow_cnt), 64'(1));
    chk("unf_valid", 64'(out_valid), 64'(0));
    for (int i = 0; i < 8; i++) begin
      cyc(1, 300 + i, 1, 1);
      if (i == 6) chk("refill7_valid", 64'(out_valid), 64'(0));
    end
    chk("refill8_valid", 64'(out_valid), 64'(0));
    cyc(0, 0, 0, 0);
    chk("refill_run_valid", 64'(out_valid), 64'(1));
    // enable drop with five frames buffered
    repeat (3) cyc(0, 0, 1, 0);
    chk("dis_pre_level", 64'(level), 64'(5));
    enable = 1'b0;
    cyc(0, 0, 0, 0);
    chk("dis_valid", 64'(out_valid), 64'(0));
    cyc(0, 0, 0, 0);
    chk("dis_level", 64'(level), 64'(0));
    chk("dis_ovf", 64'(overflow_cnt), 64'(4));
    chk("dis_unf", 64'(underflow_cnt), 64'(1));
    chk("dis_locked", 64'(locked), 64'(1));
    exp_q.delete();
    enable = 1'b1;
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 400 + i, 0, 1);
    cyc(0, 0, 0, 0);
    chk("reen_valid", 64'(out_valid), 64'(1));
    repeat (3) cyc(0, 0, 1, 0);
    chk("rst_pre_level", 64'(level), 64'(5));
    // reset pulse mid-stream
    nrst = 1'b0;
    cyc(0, 0, 0, 0);
    nrst = 1'b1;
    chk_zero("midrst");
    exp_q.delete();
    // watchdog: lock, buffer 3 frames, then go silent
    cyc(1, 32'hBEEF, 0, 0);
    chk("wd_lock", 64'(locked), 64'(1));
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 500 + i, 0, 0);
    repeat (15) cyc(0, 0, 0, 0);
    chk("wd_hold_locked", 64'(locked), 64'(1));
    chk("wd_hold_level", 64'(level), 64'(3));
    cyc(0, 0, 0, 0);
    chk("wd_drop", 64'(locked), 64'(0));
    cyc(0, 0, 0, 0);
    chk("wd_idle_level", 64'(level), 64'(3));
    chk("wd_idle_valid", 64'(out_valid), 64'(0));
    cyc(0, 0, 0, 0);
    chk("wd_flush_level", 64'(level), 64'(0));
    // resumed frame re-locks and prefill restarts
    cyc(1, 32'hCAFE, 0, 0);
    chk("relock", 64'(locked), 64'(1));
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 600 + i, 0, 1);
    chk("relock_fill_valid", 64'(out_valid), 64'(0));
    cyc(0, 0, 0, 0);
    chk("relock_run_valid", 64'(out_valid), 64'(1));
    repeat (8) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
